// File: rtl/sobel_ctrl_pkg.sv
// Shared types and constants for the Sobel window sequencer.
package sobel_ctrl_pkg;

  localparam int unsigned CNT_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    GREY = 2'd0,
    VERT = 2'd1,
    HORZ = 2'd2,
    MAG  = 2'd3
  } filt_mode_t;

endpackage

// File: rtl/sobel_valid_delay.sv
// Fixed-depth delay line that aligns window-valid with the filtered pixel at the
// datapath output. Keeps shifting whenever the clock runs; cleared only by reset.
module sobel_valid_delay #(
  parameter int unsigned DEPTH = 3
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iVALID,
  output logic oVALID
);

  logic [DEPTH-1:0] shiftQ;

  if (DEPTH == 1) begin : gSingle
    // Single-stage delay
    always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) shiftQ <= '0;
      else       shiftQ <= iVALID;
    end
  end else begin : gChain
    // Multi-stage shift toward the MSB
    always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) shiftQ <= '0;
      else       shiftQ <= {shiftQ[DEPTH-2:0], iVALID};
    end
  end

  assign oVALID = shiftQ[DEPTH-1];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequencer for the greyscale -> 3x3 line buffer -> Sobel datapath.
// Tracks pixel position, gates the line-buffer enables, flags complete 3x3
// windows and latches the filter mode at frame start.
// Optional build macro SOBEL_CTRL_STATS_EN adds oFRAME_CNT and oLINE_ERR.
module sobel_window_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic [1:0]  iMODE,
  input  logic        iMODE_WE,
  output logic        oLB_CLKEN,
  output logic        oWIN_VALID,
  output logic [1:0]  oMODE,
  output logic        oDVAL,
  output logic        oFRAME_DONE,
  output logic        oRESYNC,
  output logic [1:0]  oSTATE
`ifdef SOBEL_CTRL_STATS_EN
  ,
  output logic [15:0] oFRAME_CNT,
  output logic        oLINE_ERR
`endif
);

  localparam logic [CNT_W-1:0] LastCol = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LastRow = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] One     = CNT_W'(1);
  localparam logic [CNT_W-1:0] Two     = CNT_W'(2);

  ctrl_state_t      state;
  filt_mode_t       modeQ;
  filt_mode_t       shadowMode;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             frameStart;
  logic             inFrame;
  logic             lastCol;

  // col/row always hold the position of the next pixel to arrive.
  assign frameStart = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
  assign inFrame    = (state == PRIME) || (state == RUN);
  assign lastCol    = (col == LastCol);

  // Frame FSM, position counters, mode latch and registered strobes
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      modeQ       <= GREY;
      shadowMode  <= GREY;
      oLB_CLKEN   <= 1'b0;
      oWIN_VALID  <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oRESYNC     <= 1'b0;
    end else begin
      oLB_CLKEN   <= 1'b0;
      oWIN_VALID  <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oRESYNC     <= 1'b0;
      if (iMODE_WE) shadowMode <= filt_mode_t'(iMODE);
      if (frameStart) begin
        // A coincident write bypasses the shadow so it takes effect this frame.
        modeQ     <= iMODE_WE ? filt_mode_t'(iMODE) : shadowMode;
        col       <= One;
        row       <= '0;
        state     <= PRIME;
        oLB_CLKEN <= 1'b1;
        oRESYNC   <= inFrame;
      end else begin
        unique case (state)
          IDLE: ;
          DONE: state <= IDLE;
          PRIME, RUN: begin
            if (iDVAL) begin
              oLB_CLKEN <= 1'b1;
              if (lastCol) begin
                col <= '0;
                row <= row + One;
              end else begin
                col <= col + One;
              end
              if (state == RUN) begin
                oWIN_VALID <= (col >= Two);
                if (lastCol && (row == LastRow)) begin
                  state       <= DONE;
                  oFRAME_DONE <= 1'b1;
                end
              end else if (lastCol && (row == One)) begin
                state <= RUN;
              end
            end
          end
        endcase
      end
    end
  end

  assign oSTATE = state;
  assign oMODE  = modeQ;

  sobel_valid_delay #(
    .DEPTH (PIPE_LAT)
  ) uValidDelay (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iVALID (oWIN_VALID),
    .oVALID (oDVAL)
  );

`ifdef SOBEL_CTRL_STATS_EN
  // Completed-frame counter and sticky column-mismatch flag
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oFRAME_CNT <= '0;
      oLINE_ERR  <= 1'b0;
    end else begin
      if (oFRAME_DONE) oFRAME_CNT <= oFRAME_CNT + 16'd1;
      if (inFrame && iDVAL && (iX_Cont != col)) oLINE_ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomised bench for sobel_window_ctrl against a pixel-index reference model.
module tb_sobel_window_ctrl;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rstN;
  logic        dval;
  logic [10:0] xc;
  logic [10:0] yc;
  logic [1:0]  mode;
  logic        modeWe;
  logic        lbClkEn;
  logic        winValid;
  logic [1:0]  modeOut;
  logic        dvalOut;
  logic        frameDone;
  logic        resync;
  logic [1:0]  stateOut;
`ifdef SOBEL_CTRL_STATS_EN
  logic [15:0] frameCnt;
  logic        lineErr;
`endif

  sobel_window_ctrl #(
    .IMG_W    (W),
    .IMG_H    (H),
    .PIPE_LAT (LAT)
  ) dut (
    .iCLK        (clk),
    .iRST        (rstN),
    .iDVAL       (dval),
    .iX_Cont     (xc),
    .iY_Cont     (yc),
    .iMODE       (mode),
    .iMODE_WE    (modeWe),
    .oLB_CLKEN   (lbClkEn),
    .oWIN_VALID  (winValid),
    .oMODE       (modeOut),
    .oDVAL       (dvalOut),
    .oFRAME_DONE (frameDone),
    .oRESYNC     (resync),
    .oSTATE      (stateOut)
`ifdef SOBEL_CTRL_STATS_EN
    ,
    .oFRAME_CNT  (frameCnt),
    .oLINE_ERR   (lineErr)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mPix is the linear index of the next expected pixel (-1 = no frame).
  int mPix;
  bit mDone;
  int mShadow;
  int mFrames;
  bit mLineErr;
  bit hist [LAT];
  bit eClk, eWin, eDval, eDone, eResync;
  int eMode;

  // Pulse tallies since the last clearCounts
  int cntClk, cntWin, cntDval, cntDone;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int expState();
    if (mDone)    return 3;
    if (mPix < 0) return 0;
    if (mPix < 2 * W) return 1;
    return 2;
  endfunction

  task automatic modelReset();
    mPix = -1; mDone = 0; mShadow = 0; mFrames = 0; mLineErr = 0;
    for (int i = 0; i < LAT; i++) hist[i] = 0;
    eClk = 0; eWin = 0; eDval = 0; eDone = 0; eResync = 0; eMode = 0;
  endtask

  task automatic modelStep(input bit dv, input int x, input int y, input int md, input bit we);
    bit fs;
    bit win;
    fs  = dv && (x == 0) && (y == 0);
    win = 0;
    eDval = hist[LAT-1];
    if (mDone) mFrames = (mFrames + 1) % 65536;
    if (dv && mPix >= 0 && !mDone && x != mPix % W) mLineErr = 1;
    eClk = 0; eDone = 0; eResync = 0;
    if (fs) begin
      eResync = (mPix >= 0) && !mDone;
      eMode   = we ? md : mShadow;
      mPix    = 1;
      mDone   = 0;
      eClk    = 1;
    end else if (mDone) begin
      mDone = 0;
      mPix  = -1;
    end else if (dv && mPix >= 0) begin
      eClk = 1;
      win  = (mPix / W >= 2) && (mPix % W >= 2);
      if (mPix == W * H - 1) begin
        mDone = 1;
        eDone = 1;
        mPix  = -1;
      end else begin
        mPix++;
      end
    end
    if (we) mShadow = md;
    eWin = win;
    for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = win;
  endtask

  task automatic checkOutputs();
    checkEq("clken", lbClkEn, eClk);
    checkEq("winValid", winValid, eWin);
    checkEq("dvalOut", dvalOut, eDval);
    checkEq("frameDone", frameDone, eDone);
    checkEq("resync", resync, eResync);
    checkEq("mode", modeOut, eMode);
    checkEq("state", stateOut, expState());
`ifdef SOBEL_CTRL_STATS_EN
    checkEq("frameCnt", frameCnt, mFrames);
    checkEq("lineErr", lineErr, mLineErr);
`endif
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check just after it.
  task automatic cycle(input bit dv, input int x, input int y, input int md, input bit we);
    dval = dv; xc = 11'(x); yc = 11'(y); mode = 2'(md); modeWe = we;
    @(posedge clk);
    modelStep(dv, x, y, md, we);
    #1;
    checkOutputs();
    cntClk  += int'(lbClkEn);
    cntWin  += int'(winValid);
    cntDval += int'(dvalOut);
    cntDone += int'(frameDone);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, $urandom_range(0, 2047), $urandom_range(0, 2047), 0, 0);
  endtask

  task automatic clearCounts();
    cntClk = 0; cntWin = 0; cntDval = 0; cntDone = 0;
  endtask

  // Send pixels first..last of a frame with optional gaps, random mode writes and one bad column.
  task automatic sendRange(input int first, input int last, input int fixedGap, input int randPct,
                           input bit randMode, input int badPix);
    for (int p = first; p <= last; p++) begin
      int x;
      bit we;
      int md;
      while ($urandom_range(0, 99) < randPct) begin
        we = randMode && ($urandom_range(0, 7) == 0);
        cycle(0, $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 3), we);
      end
      x  = (p == badPix) ? (p % W) + 1 : p % W;
      we = randMode && ($urandom_range(0, 7) == 0);
      md = $urandom_range(0, 3);
      cycle(1, x, p / W, md, we);
      idle(fixedGap);
    end
  endtask

  // Assert reset between edges, check the asynchronous clear, then release.
  task automatic doReset();
    #2;
    rstN = 1'b0;
    dval = 1'b0; modeWe = 1'b0;
    #1;
    checkEq("rstClken", lbClkEn, 0);
    checkEq("rstWinValid", winValid, 0);
    checkEq("rstDvalOut", dvalOut, 0);
    checkEq("rstFrameDone", frameDone, 0);
    checkEq("rstResync", resync, 0);
    checkEq("rstMode", modeOut, 0);
    checkEq("rstState", stateOut, 0);
`ifdef SOBEL_CTRL_STATS_EN
    checkEq("rstFrameCnt", frameCnt, 0);
    checkEq("rstLineErr", lineErr, 0);
`endif
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b1; dval = 0; xc = '0; yc = '0; mode = '0; modeWe = 0;
    modelReset();
    clearCounts();
    @(posedge clk);
    #1;
    doReset();

    // Pixels before any frame start are ignored
    for (int i = 0; i < 10; i++) cycle(1, 5, $urandom_range(1, 10), 0, 0);
    checkEq("preFsClken", cntClk, 0);
    checkEq("preFsState", stateOut, 0);

    // One contiguous frame
    clearCounts();
    sendRange(0, W * H - 1, 0, 0, 0, -1);
    idle(5);
    checkEq("frameClken", cntClk, W * H);
    checkEq("frameWin", cntWin, 12);
    checkEq("frameDval", cntDval, 12);
    checkEq("frameDoneCnt", cntDone, 1);
    checkEq("frameEndState", stateOut, 0);

    // Mode latching at frame boundaries
    cycle(0, 0, 0, 1, 1);
    sendRange(0, 10, 0, 0, 0, -1);
    checkEq("modeLatched1", modeOut, 1);
    cycle(1, 11 % W, 11 / W, 2, 1);
    sendRange(12, W * H - 1, 0, 0, 0, -1);
    idle(2);
    checkEq("modeHeld1", modeOut, 1);
    sendRange(0, W * H - 1, 0, 0, 0, -1);
    checkEq("modeNext2", modeOut, 2);
    cycle(1, 0, 0, 3, 1);
    checkEq("modeBypass3", modeOut, 3);
    sendRange(1, W * H - 1, 0, 0, 0, -1);
    idle(3);

    // Resync at row 2, col 4
    sendRange(0, 2 * W + 3, 0, 0, 0, -1);
    cycle(1, 0, 0, 0, 0);
    checkEq("resyncPulse", resync, 1);
    checkEq("resyncState", stateOut, 1);
    clearCounts();
    sendRange(1, 2 * W - 1, 0, 0, 0, -1);
    checkEq("resyncNoWin", cntWin, 0);
    checkEq("resyncNoDone", cntDone, 0);
    sendRange(2 * W, W * H - 1, 0, 0, 0, -1);
    idle(5);

    // One valid every three cycles
    clearCounts();
    sendRange(0, W * H - 1, 2, 0, 0, -1);
    idle(5);
    checkEq("gapWin", cntWin, 12);
    checkEq("gapDval", cntDval, 12);
    checkEq("gapDone", cntDone, 1);

    // Random gaps, mode writes and truncated frames
    for (int k = 0; k < 10; k++) begin
      int last;
      last = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W * H - 2) : W * H - 1;
      sendRange(0, last, 0, 30, 1, -1);
      idle($urandom_range(0, 3));
    end
    idle(5);

`ifdef SOBEL_CTRL_STATS_EN
    doReset();
    for (int k = 0; k < 3; k++) sendRange(0, W * H - 1, 0, 0, 0, -1);
    idle(2);
    checkEq("statsFrames3", frameCnt, 3);
    checkEq("statsCleanErr", lineErr, 0);
    sendRange(0, W * H - 1, 0, 0, 0, W + 2);
    idle(2);
    checkEq("statsSkipErr", lineErr, 1);
    sendRange(0, W * H - 1, 0, 0, 0, -1);
    idle(2);
    checkEq("statsStickyErr", lineErr, 1);
    checkEq("statsFrames5", frameCnt, 5);
`endif

    // Reset in the middle of RUN with windows still in flight
    sendRange(0, 2 * W + 6, 0, 0, 0, -1);
    doReset();
    clearCounts();
    sendRange(0, W * H - 1, 0, 0, 0, -1);
    idle(5);
    checkEq("postRstWin", cntWin, 12);
    checkEq("postRstDone", cntDone, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
